// File: rtl/acc_array_sat_if.sv
// Bundle of config, input-beat and result signals for acc_array_sat.
// The slave modport is the accumulator block; master is its sequencer/producer side.
interface acc_array_sat_if #(
    parameter int unsigned CH        = 4,
    parameter int unsigned IN_BIT    = 16,
    parameter int unsigned ACC_BIT   = 24,
    parameter int unsigned OUT_BIT   = 8,
    parameter int unsigned LEN_BIT   = 8,
    parameter int unsigned SHIFT_BIT = 5
) ();
    logic                     start;
    logic [LEN_BIT-1:0]       len;
    logic [SHIFT_BIT-1:0]     shift;
    logic                     relu_en;
    logic [CH*ACC_BIT-1:0]    bias;
    logic                     in_valid;
    logic                     in_ready;
    logic [CH*IN_BIT-1:0]     in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [CH*OUT_BIT-1:0]    out_data;
    logic                     busy;
    logic [CH-1:0]            sat_flag;

    modport master (
        output start, len, shift, relu_en, bias, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, sat_flag
    );

    modport slave (
        input  start, len, shift, relu_en, bias, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, sat_flag
    );
endinterface

// File: rtl/acc_array_sat.sv
// Multi-channel saturating accumulator: sums CH signed lanes over a window of beats,
// then requantises (shift, optional ReLU, clamp) and hands the result out on valid/ready.
module acc_array_sat #(
    parameter int unsigned CH        = 4,
    parameter int unsigned IN_BIT    = 16,
    parameter int unsigned ACC_BIT   = 24,
    parameter int unsigned OUT_BIT   = 8,
    parameter int unsigned LEN_BIT   = 8,
    parameter int unsigned SHIFT_BIT = 5
) (
    input logic            clk,
    input logic            rst,
    acc_array_sat_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAcc, StScale, StOut} state_e;

    localparam logic [ACC_BIT-1:0] AccMax = {1'b0, {(ACC_BIT-1){1'b1}}};
    localparam logic [ACC_BIT-1:0] AccMin = {1'b1, {(ACC_BIT-1){1'b0}}};
    localparam logic [OUT_BIT-1:0] OutMax = {1'b0, {(OUT_BIT-1){1'b1}}};
    localparam logic [OUT_BIT-1:0] OutMin = {1'b1, {(OUT_BIT-1){1'b0}}};

    state_e                 state_q, state_d;
    logic [LEN_BIT-1:0]     len_q, len_d, cnt_q, cnt_d;
    logic [SHIFT_BIT-1:0]   shift_q, shift_d;
    logic                   relu_q, relu_d;
    logic [ACC_BIT-1:0]     acc_q [CH];
    logic [ACC_BIT-1:0]     acc_d [CH];
    logic [CH*OUT_BIT-1:0]  out_q, out_d;
    logic [CH-1:0]          sat_q, sat_d;

    logic                   beat, last_beat;
    logic [ACC_BIT-1:0]     acc_add [CH];
    logic [CH-1:0]          acc_ovf, out_clip;
    logic [CH*OUT_BIT-1:0]  quant;

    assign beat      = (state_q == StAcc) && bus.in_valid;
    assign last_beat = beat && (cnt_q == len_q - LEN_BIT'(1));

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [IN_BIT-1:0]  lane;
        logic [ACC_BIT:0]   sum;
        logic [ACC_BIT-1:0] shr, t;
        logic               fits;

        // One guard bit: overflow iff the top two bits of the widened sum disagree.
        assign lane = bus.in_data[c*IN_BIT +: IN_BIT];
        assign sum  = {acc_q[c][ACC_BIT-1], acc_q[c]}
                    + {{(ACC_BIT+1-IN_BIT){lane[IN_BIT-1]}}, lane};
        assign acc_ovf[c] = sum[ACC_BIT] != sum[ACC_BIT-1];
        assign acc_add[c] = acc_ovf[c] ? (sum[ACC_BIT] ? AccMin : AccMax) : sum[ACC_BIT-1:0];

        assign shr  = ACC_BIT'($signed(acc_q[c]) >>> shift_q);
        assign t    = (relu_q && shr[ACC_BIT-1]) ? '0 : shr;
        assign fits = (&t[ACC_BIT-1:OUT_BIT-1]) | ~(|t[ACC_BIT-1:OUT_BIT-1]);
        assign out_clip[c] = ~fits;
        assign quant[c*OUT_BIT +: OUT_BIT] = fits ? t[OUT_BIT-1:0]
                                                  : (t[ACC_BIT-1] ? OutMin : OutMax);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            out_q   <= '0;
            sat_q   <= '0;
            for (int c = 0; c < CH; c++) acc_q[c] <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
            out_q   <= out_d;
            sat_q   <= sat_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StAcc;
            StAcc:   if (last_beat) state_d = StScale;
            StScale: state_d = StOut;
            StOut:   if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        len_d   = len_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        out_d   = out_q;
        sat_d   = sat_q;
        acc_d   = acc_q;
        if (state_q == StIdle && bus.start) begin
            len_d   = (bus.len == '0) ? LEN_BIT'(1) : bus.len;
            shift_d = bus.shift;
            relu_d  = bus.relu_en;
            cnt_d   = '0;
            sat_d   = '0;
            for (int c = 0; c < CH; c++) acc_d[c] = bus.bias[c*ACC_BIT +: ACC_BIT];
        end else if (beat) begin
            cnt_d = cnt_q + LEN_BIT'(1);
            sat_d = sat_q | acc_ovf;
            acc_d = acc_add;
        end else if (state_q == StScale) begin
            out_d = quant;
            sat_d = sat_q | out_clip;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == StAcc);
        bus.out_valid = (state_q == StOut);
        bus.busy      = (state_q != StIdle);
        bus.out_data  = out_q;
        bus.sat_flag  = sat_q;
    end
endmodule
